edge_corner_finder: RTL and testbench

EDGE_CORNER_FINDER -- requirements
Module: edge_corner_finder

---
 rtl/edge_corner_finder.sv | 176 +++++++++++++++++
 tb/tb_edge_corner_finder.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/edge_corner_finder.sv
// Raster-scans a 1-bit edge map through a fixed-latency read port and keeps the
// extreme edge pixels along the x+y and x-y diagonals as the four corners.
module edge_corner_finder #(
    parameter int WIDTH        = 640,
    parameter int HEIGHT       = 480,
    parameter int READ_LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic        done,
    output logic [18:0] read_addr,
    input  logic        read_data,
    output logic        found,
    output logic [9:0]  tl_x,
    output logic [8:0]  tl_y,
    output logic [9:0]  tr_x,
    output logic [8:0]  tr_y,
    output logic [9:0]  bl_x,
    output logic [8:0]  bl_y,
    output logic [9:0]  br_x,
    output logic [8:0]  br_y
);

    typedef enum logic [1:0] {IDLE, SCAN, DRAIN, FINISH} state_t;

    localparam logic [9:0] X_LAST     = 10'(WIDTH - 1);
    localparam logic [8:0] Y_LAST     = 9'(HEIGHT - 1);
    localparam logic [1:0] DRAIN_LAST = 2'(READ_LATENCY - 1);

    state_t             state_q, state_d;
    logic [9:0]         x_q;
    logic [8:0]         y_q;
    logic [1:0]         drain_cnt_q;
    logic               pend_q;
    logic               launch;
    logic               last_addr;

    logic               dl_v [1:READ_LATENCY];
    logic [9:0]         dl_x [1:READ_LATENCY];
    logic [8:0]         dl_y [1:READ_LATENCY];

    logic               px_hit;
    logic [9:0]         px_x;
    logic [8:0]         px_y;
    logic [10:0]        s_new;
    logic signed [10:0] d_new;
    logic [10:0]        min_s_q, max_s_q;
    logic signed [10:0] max_d_q, min_d_q;

    assign read_addr = {y_q, x_q};
    assign last_addr = (x_q == X_LAST) && (y_q == Y_LAST);

    // A start seen in FINISH is parked in pend_q so the done pulse still shows this scan's results.
    assign launch = (state_q == IDLE) ? (start || pend_q)
                                      : (start && (state_q == SCAN || state_q == DRAIN));

    // NOTE: registers use <= so every flop samples the values from before the edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // NOTE: state_d gets its default first, so no path through the case can infer a latch.
    always_comb begin
        state_d = state_q;
        if (launch) begin
            state_d = SCAN;
        end else begin
            case (state_q)
                IDLE:    state_d = IDLE;
                SCAN:    if (last_addr) state_d = DRAIN;
                DRAIN:   if (drain_cnt_q == DRAIN_LAST) state_d = FINISH;
                FINISH:  state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            x_q         <= '0;
            y_q         <= '0;
            drain_cnt_q <= '0;
            pend_q      <= 1'b0;
            done        <= 1'b0;
        end else begin
            done   <= (state_q == FINISH);
            pend_q <= (state_q == FINISH) && start;
            if (launch) begin
                x_q <= '0;
                y_q <= '0;
            end else if (state_q == SCAN && !last_addr) begin
                if (x_q == X_LAST) begin
                    x_q <= '0;
                    y_q <= y_q + 9'd1;
                end else begin
                    x_q <= x_q + 10'd1;
                end
            end
            if (state_q == SCAN)       drain_cnt_q <= '0;
            else if (state_q == DRAIN) drain_cnt_q <= drain_cnt_q + 2'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 1; i <= READ_LATENCY; i++) dl_v[i] <= 1'b0;
        end else if (launch) begin
            for (int i = 1; i <= READ_LATENCY; i++) dl_v[i] <= 1'b0;
        end else begin
            dl_v[1] <= (state_q == SCAN);
            for (int i = 2; i <= READ_LATENCY; i++) dl_v[i] <= dl_v[i-1];
        end
    end

    // NOTE: coordinate stages carry no reset; dl_v alone decides whether a stage is meaningful.
    always_ff @(posedge clk) begin
        dl_x[1] <= x_q;
        dl_y[1] <= y_q;
        for (int i = 2; i <= READ_LATENCY; i++) begin
            dl_x[i] <= dl_x[i-1];
            dl_y[i] <= dl_y[i-1];
        end
    end

    assign px_x   = dl_x[READ_LATENCY];
    assign px_y   = dl_y[READ_LATENCY];
    assign px_hit = dl_v[READ_LATENCY] && read_data;
    assign s_new  = {1'b0, px_x} + {2'b00, px_y};
    assign d_new  = $signed({1'b0, px_x}) - $signed({2'b00, px_y});

    // Strict compares keep the raster-first pixel on ties; !found seeds all four corners.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            found   <= 1'b0;
            tl_x <= '0; tl_y <= '0; tr_x <= '0; tr_y <= '0;
            bl_x <= '0; bl_y <= '0; br_x <= '0; br_y <= '0;
            min_s_q <= 11'd2047;
            max_s_q <= 11'd0;
            max_d_q <= -11'sd1024;
            min_d_q <= 11'sd1023;
        end else if (launch) begin
            found   <= 1'b0;
            tl_x <= '0; tl_y <= '0; tr_x <= '0; tr_y <= '0;
            bl_x <= '0; bl_y <= '0; br_x <= '0; br_y <= '0;
            min_s_q <= 11'd2047;
            max_s_q <= 11'd0;
            max_d_q <= -11'sd1024;
            min_d_q <= 11'sd1023;
        end else if (px_hit) begin
            found <= 1'b1;
            if (!found || s_new < min_s_q) begin
                min_s_q <= s_new;
                tl_x    <= px_x;
                tl_y    <= px_y;
            end
            if (!found || s_new > max_s_q) begin
                max_s_q <= s_new;
                br_x    <= px_x;
                br_y    <= px_y;
            end
            if (!found || d_new > max_d_q) begin
                max_d_q <= d_new;
                tr_x    <= px_x;
                tr_y    <= px_y;
            end
            if (!found || d_new < min_d_q) begin
                min_d_q <= d_new;
                bl_x    <= px_x;
                bl_y    <= px_y;
            end
        end
    end

endmodule

// File: tb/tb_edge_corner_finder.sv
// Bench for edge_corner_finder on a reduced 40x24 map: directed and random edge maps
// compared against a two-pass extreme-point reference model of the corner rules.
module tb_edge_corner_finder;

    localparam int W        = 40;
    localparam int H        = 24;
    localparam int RL       = 2;
    localparam int NPIX     = W * H;
    localparam int SCAN_CYC = NPIX + RL + 1;

    logic        clk       = 1'b0;
    logic        reset     = 1'b1;
    logic        start     = 1'b0;
    logic        read_data = 1'b0;
    logic        done;
    logic        found;
    logic [18:0] read_addr;
    logic [9:0]  tl_x, tr_x, bl_x, br_x;
    logic [8:0]  tl_y, tr_y, bl_y, br_y;

    int n_cmp  = 0;
    int n_fail = 0;

    bit   edge_map [0:H-1][0:W-1];
    logic dpipe [0:RL] = '{default: 1'b0};

    typedef struct {
        int found;
        int tl_x, tl_y, tr_x, tr_y, bl_x, bl_y, br_x, br_y;
    } exp_t;

    edge_corner_finder #(.WIDTH(W), .HEIGHT(H), .READ_LATENCY(RL)) dut (
        .clk(clk), .reset(reset), .start(start), .done(done),
        .read_addr(read_addr), .read_data(read_data), .found(found),
        .tl_x(tl_x), .tl_y(tl_y), .tr_x(tr_x), .tr_y(tr_y),
        .bl_x(bl_x), .bl_y(bl_y), .br_x(br_x), .br_y(br_y)
    );

    always #5 clk = ~clk;

    function automatic bit map_at(input logic [18:0] a);
        int x = int'(a[9:0]);
        int y = int'(a[18:10]);
        if (x < W && y < H) return edge_map[y][x];
        return 1'b0;
    endfunction

    // Edge-map memory: the bit for an address appears RL clocks after it is presented.
    always @(negedge clk) begin
        for (int i = RL; i > 0; i--) dpipe[i] = dpipe[i-1];
        dpipe[0]  = map_at(read_addr);
        read_data = dpipe[RL];
    end

    // Reference: find the extreme x+y and x-y values, then the raster-first pixel reaching each.
    function automatic exp_t model();
        exp_t e = '{default: 0};
        int s_lo = 1 << 30, s_hi = -1, d_lo = 1 << 30, d_hi = -(1 << 30);
        bit got_tl = 0, got_tr = 0, got_bl = 0, got_br = 0;
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++)
                if (edge_map[y][x]) begin
                    e.found = 1;
                    if (x + y < s_lo) s_lo = x + y;
                    if (x + y > s_hi) s_hi = x + y;
                    if (x - y < d_lo) d_lo = x - y;
                    if (x - y > d_hi) d_hi = x - y;
                end
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++)
                if (edge_map[y][x]) begin
                    if (!got_tl && x + y == s_lo) begin e.tl_x = x; e.tl_y = y; got_tl = 1; end
                    if (!got_br && x + y == s_hi) begin e.br_x = x; e.br_y = y; got_br = 1; end
                    if (!got_bl && x - y == d_lo) begin e.bl_x = x; e.bl_y = y; got_bl = 1; end
                    if (!got_tr && x - y == d_hi) begin e.tr_x = x; e.tr_y = y; got_tr = 1; end
                end
        return e;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_results(input string tag);
        exp_t e;
        e = model();
        check({tag, " found"}, found, e.found);
        check({tag, " tl_x"}, tl_x, e.tl_x);
        check({tag, " tl_y"}, tl_y, e.tl_y);
        check({tag, " tr_x"}, tr_x, e.tr_x);
        check({tag, " tr_y"}, tr_y, e.tr_y);
        check({tag, " bl_x"}, bl_x, e.bl_x);
        check({tag, " bl_y"}, bl_y, e.bl_y);
        check({tag, " br_x"}, br_x, e.br_x);
        check({tag, " br_y"}, br_y, e.br_y);
    endtask

    task automatic check_zero(input string tag);
        check({tag, " done"}, done, 0);
        check({tag, " found"}, found, 0);
        check({tag, " read_addr"}, read_addr, 0);
        check({tag, " tl_x"}, tl_x, 0);
        check({tag, " tl_y"}, tl_y, 0);
        check({tag, " tr_x"}, tr_x, 0);
        check({tag, " tr_y"}, tr_y, 0);
        check({tag, " bl_x"}, bl_x, 0);
        check({tag, " bl_y"}, bl_y, 0);
        check({tag, " br_x"}, br_x, 0);
        check({tag, " br_y"}, br_y, 0);
    endtask

    task automatic clear_map();
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++) edge_map[y][x] = 1'b0;
    endtask

    task automatic fill_map();
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++) edge_map[y][x] = 1'b1;
    endtask

    task automatic random_map(input int pct);
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++) edge_map[y][x] = ($urandom_range(99) < pct);
    endtask

    // Returns on the falling edge right after the clock that samples start.
    task automatic pulse_start();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int n);
        n = 0;
        while (done !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic scan_and_check(input string tag);
        int n;
        pulse_start();
        wait_done(SCAN_CYC + 20, n);
        check({tag, " latency"}, n, SCAN_CYC);
        check_results(tag);
        check({tag, " last addr"}, read_addr, {9'(H - 1), 10'(W - 1)});
        @(negedge clk);
        check({tag, " done width"}, done, 0);
    endtask

    initial begin
        int n;
        int dones;
        int pct [4] = '{1, 4, 25, 60};

        clear_map();
        #2 reset = 1'b0;
        #1 check_zero("reset");
        repeat (2) @(negedge clk);
        reset = 1'b1;

        clear_map();
        edge_map[9][17] = 1'b1;
        scan_and_check("single");
        check("single tl_x", tl_x, 17);
        check("single br_y", br_y, 9);

        clear_map();
        edge_map[2][2] = 1'b1;
        edge_map[3][35] = 1'b1;
        edge_map[21][3] = 1'b1;
        edge_map[22][37] = 1'b1;
        scan_and_check("corners");
        check("corners tr_x", tr_x, 35);
        check("corners bl_y", bl_y, 21);

        clear_map();
        scan_and_check("empty");
        dones = 0;
        repeat (30) begin
            @(negedge clk);
            if (done) dones++;
        end
        check("empty extra done", dones, 0);

        clear_map();
        edge_map[5][5] = 1'b1;
        edge_map[6][4] = 1'b1;
        scan_and_check("tie");
        check("tie tl_x", tl_x, 5);
        check("tie tl_y", tl_y, 5);
        repeat (25) @(negedge clk);
        check_results("hold");

        for (int k = 0; k < 4; k++) begin
            random_map(pct[k]);
            scan_and_check($sformatf("rand%0d", k));
        end

        fill_map();
        pulse_start();
        repeat (100) @(negedge clk);
        check("abort early done", done, 0);
        clear_map();
        edge_map[H-2][W-3] = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(SCAN_CYC + 20, n);
        check("abort latency", n, SCAN_CYC);
        check_results("abort");
        check("abort tl_x", tl_x, W - 3);

        random_map(10);
        pulse_start();
        repeat (SCAN_CYC - 1) @(negedge clk);
        check("fin pre-done", done, 0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("fin done", done, 1);
        check_results("fin first");
        random_map(20);
        @(negedge clk);
        check("fin done width", done, 0);
        wait_done(SCAN_CYC + 20, n);
        check("fin restart completes", (n < SCAN_CYC + 20), 1);
        check_results("fin second");

        random_map(50);
        pulse_start();
        repeat (500) @(negedge clk);
        reset = 1'b0;
        #1 check_zero("mid reset");
        repeat (2) @(negedge clk);
        reset = 1'b1;
        dones = 0;
        repeat (SCAN_CYC + 10) begin
            @(negedge clk);
            if (done) dones++;
        end
        check("mid reset no done", dones, 0);
        scan_and_check("after reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
